// File: rtl/cp0_unit.sv
// Coprocessor-0 register block: Count/Compare timer, Status/Cause/EPC,
// exception and ERET commit, interrupt request and vector target generation.
module cp0_unit #(
  parameter int          COUNT_DIV    = 2,
  parameter int          HW_INT_NUM   = 6,
  parameter int          TIMER_IP     = 7,
  parameter logic [31:0] STATUS_WMASK = 32'h0040FF03,
  parameter logic [31:0] PRID_VAL     = 32'h004C0102,
  parameter logic [31:0] CONFIG_VAL   = 32'h00008000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [4:0]            raddr_i,
  input  logic [31:0]           data_i,
  input  logic [HW_INT_NUM-1:0] int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  exc_bd_i,
  input  logic [31:0]           bad_addr_i,
  input  logic                  eret_i,
  output logic [31:0]           data_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic [31:0]           count_o,
  output logic                  int_pending_o,
  output logic [31:0]           exc_target_o
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  logic [31:0]           badvaddr_q, badvaddr_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic [31:0]           status_q, status_d;
  logic [31:0]           epc_q, epc_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic                  bd_q, bd_d;
  logic                  ti_q, ti_d;
  logic [1:0]            ip_sw_q, ip_sw_d;
  logic [4:0]            exccode_q, exccode_d;
  logic [HW_INT_NUM-1:0] ip_hw_q, ip_hw_d;

  logic        wr;
  logic        tick;
  logic [31:0] count_inc;
  logic [7:0]  ip_view;
  logic [31:0] cause_w;

  always_ff @(posedge clk) begin
    if (!rst) begin
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      status_q   <= 32'h00400000;
      epc_q      <= '0;
      presc_q    <= '0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_sw_q    <= '0;
      exccode_q  <= '0;
      ip_hw_q    <= '0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      epc_q      <= epc_d;
      presc_q    <= presc_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
      ip_hw_q    <= ip_hw_d;
    end
  end

  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q;
    compare_d  = compare_q;
    status_d   = status_q;
    epc_d      = epc_q;
    presc_d    = presc_q;
    bd_d       = bd_q;
    ti_d       = ti_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    ip_hw_d    = int_i;

    // Any commit event in this cycle swallows the MTC0 completely.
    wr        = we_i & ~exc_valid_i & ~eret_i;
    tick      = (presc_q == PRESC_MAX);
    count_inc = count_q + 32'd1;

    if (wr && waddr_i == 5'd9) begin
      count_d = data_i;
      presc_d = '0;
    end else if (tick) begin
      count_d = count_inc;
      presc_d = '0;
      if (count_inc == compare_q) ti_d = 1'b1;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (wr) begin
      case (waddr_i)
        5'd11: begin
          compare_d = data_i;
          ti_d      = 1'b0;
        end
        5'd12:   status_d = (status_q & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
        5'd13:   ip_sw_d  = data_i[9:8];
        5'd14:   epc_d    = data_i;
        default: ;
      endcase
    end

    if (exc_valid_i) begin
      // A nested exception keeps the EPC/BD of the outer one.
      if (!status_q[1]) begin
        epc_d = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
        bd_d  = exc_bd_i;
      end
      exccode_d   = exc_code_i;
      status_d[1] = 1'b1;
      if (exc_code_i == 5'd4 || exc_code_i == 5'd5) badvaddr_d = bad_addr_i;
    end else if (eret_i) begin
      status_d[1] = 1'b0;
    end
  end

  always_comb begin
    ip_view           = {6'(ip_hw_q), ip_sw_q};
    ip_view[TIMER_IP] = ip_view[TIMER_IP] | ti_q;
  end

  assign cause_w = {bd_q, ti_q, 14'b0, ip_view, 1'b0, exccode_q, 2'b0};

  always_comb begin
    data_o = '0;
    if (rst) begin
      case (raddr_i)
        5'd8:    data_o = badvaddr_q;
        5'd9:    data_o = count_q;
        5'd11:   data_o = compare_q;
        5'd12:   data_o = status_q;
        5'd13:   data_o = cause_w;
        5'd14:   data_o = epc_q;
        5'd15:   data_o = PRID_VAL;
        5'd16:   data_o = CONFIG_VAL;
        default: data_o = '0;
      endcase
    end
  end

  assign int_pending_o = status_q[0] & ~status_q[1] & (|(ip_view & status_q[15:8]));

  always_comb begin
    if (eret_i && !exc_valid_i) exc_target_o = epc_q;
    else if (status_q[22])      exc_target_o = 32'hBFC00380;
    else                        exc_target_o = 32'h80000180;
  end

  assign status_o = status_q;
  assign cause_o  = cause_w;
  assign epc_o    = epc_q;
  assign count_o  = count_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit with default parameters (COUNT_DIV=2).
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i, raddr_i;
  logic [31:0] data_i;
  logic [5:0]  int_i;
  logic        exc_valid_i;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic        exc_bd_i;
  logic [31:0] bad_addr_i;
  logic        eret_i;
  logic [31:0] data_o, status_o, cause_o, epc_o, count_o, exc_target_o;
  logic        int_pending_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cp0_unit dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
    .data_i(data_i), .int_i(int_i), .exc_valid_i(exc_valid_i),
    .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i), .exc_bd_i(exc_bd_i),
    .bad_addr_i(bad_addr_i), .eret_i(eret_i), .data_o(data_o),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .count_o(count_o),
    .int_pending_o(int_pending_o), .exc_target_o(exc_target_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; data_i = d;
    cyc(1);
    we_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0; we_i = 1'b0; waddr_i = '0; raddr_i = 5'd12; data_i = '0;
    int_i = '0; exc_valid_i = 1'b0; exc_code_i = '0; exc_pc_i = '0;
    exc_bd_i = 1'b0; bad_addr_i = '0; eret_i = 1'b0;

    cyc(2);
    check("rst_status", status_o, 32'h00400000);
    check("rst_cause", cause_o, 32'h0);
    check("rst_count", count_o, 32'h0);
    check("rst_read", data_o, 32'h0);

    // Count prescaling and wrap; Compare==0 matches on the wrap tick
    rst = 1'b1;
    cyc(10);
    check("count_div", count_o, 32'd5);
    raddr_i = 5'd9; we_i = 1'b1; waddr_i = 5'd9; data_i = 32'hFFFFFFFF;
    #1;
    check("read_old_on_write", data_o, 32'd5);
    cyc(1);
    we_i = 1'b0;
    check("count_load", count_o, 32'hFFFFFFFF);
    cyc(2);
    check("count_wrap", count_o, 32'h0);
    check("ti_compare0", 32'(cause_o[30]), 32'd1);

    // Timer interrupt
    mtc0(5'd11, 32'd3);
    check("ti_clr_cmp", 32'(cause_o[30]), 32'd0);
    mtc0(5'd12, 32'h00408001);
    check("status_wr", status_o, 32'h00408001);
    mtc0(5'd9, 32'd0);
    cyc(5);
    check("count_pre", count_o, 32'd2);
    check("ti_pre", 32'(cause_o[30]), 32'd0);
    cyc(1);
    check("count_match", count_o, 32'd3);
    check("ti_set", 32'(cause_o[30]), 32'd1);
    check("ip7_set", 32'(cause_o[15]), 32'd1);
    check("pend_timer", 32'(int_pending_o), 32'd1);
    mtc0(5'd11, 32'd100);
    check("ti_clear", 32'(cause_o[30]), 32'd0);
    check("pend_clear", 32'(int_pending_o), 32'd0);

    // Hardware and software interrupt bits
    int_i = 6'b000001;
    cyc(1);
    check("hw_ip2", cause_o, 32'h00000400);
    mtc0(5'd12, 32'h00408401);
    check("pend_hw", 32'(int_pending_o), 32'd1);
    int_i = '0;
    mtc0(5'd13, 32'hFFFFFFFF);
    check("sw_ip", cause_o, 32'h00000300);
    mtc0(5'd13, 32'h0);

    // Exception in a delay slot with BadVAddr capture
    exc_valid_i = 1'b1; exc_code_i = 5'd4; exc_pc_i = 32'hBFC00104;
    exc_bd_i = 1'b1; bad_addr_i = 32'h00000003;
    #1;
    check("vec_bev", exc_target_o, 32'hBFC00380);
    cyc(1);
    exc_valid_i = 1'b0; raddr_i = 5'd8;
    #1;
    check("exc_epc", epc_o, 32'hBFC00100);
    check("exc_bd", 32'(cause_o[31]), 32'd1);
    check("exc_code", 32'(cause_o[6:2]), 32'd4);
    check("exc_badv", data_o, 32'h3);
    check("exc_exl", 32'(status_o[1]), 32'd1);

    // Nested exception, then ERET
    exc_valid_i = 1'b1; exc_code_i = 5'd8; exc_pc_i = 32'h80001000;
    exc_bd_i = 1'b0; bad_addr_i = 32'hDEADBEEF;
    cyc(1);
    exc_valid_i = 1'b0;
    check("nest_epc", epc_o, 32'hBFC00100);
    check("nest_bd", 32'(cause_o[31]), 32'd1);
    check("nest_code", 32'(cause_o[6:2]), 32'd8);
    check("nest_badv", data_o, 32'h3);
    eret_i = 1'b1;
    #1;
    check("eret_target", exc_target_o, 32'hBFC00100);
    cyc(1);
    eret_i = 1'b0;
    check("eret_exl", 32'(status_o[1]), 32'd0);

    // Exception beats a same-cycle MTC0; Status write mask
    we_i = 1'b1; waddr_i = 5'd14; data_i = 32'h00001234;
    exc_valid_i = 1'b1; exc_code_i = 5'd0; exc_pc_i = 32'h80000020; exc_bd_i = 1'b0;
    cyc(1);
    we_i = 1'b0; exc_valid_i = 1'b0;
    check("exc_over_mtc0", epc_o, 32'h80000020);
    mtc0(5'd12, 32'hFFFFFFFF);
    check("status_mask", status_o, 32'h0040FF03);

    // Reset during an exception cycle
    exc_valid_i = 1'b1; exc_code_i = 5'd5; exc_pc_i = 32'h80004000;
    rst = 1'b0; raddr_i = 5'd12;
    cyc(1);
    exc_valid_i = 1'b0;
    check("rst2_status", status_o, 32'h00400000);
    check("rst2_cause", cause_o, 32'h0);
    check("rst2_epc", epc_o, 32'h0);
    check("rst2_count", count_o, 32'h0);
    check("rst2_read", data_o, 32'h0);
    rst = 1'b1;
    cyc(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
